// File: rtl/rom_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rom_loader
//
// Loads an iNES cartridge image from an RS232 byte stream into the 64 KB
// image RAM. Header, PRG and CHR bytes go to consecutive addresses from
// 0x0000, so PRG lands at 0x0010 and CHR at 0x4010. While a load runs the
// CPU is held off the bus.
//
// Only 16 KB PRG / 8 KB CHR mapper-0 (NROM) images are accepted. The header
// is checked byte by byte as it streams past, and every checked byte is
// still written.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   prg_ctrl   programming request level; a rising edge starts a load and
//              dropping it mid-load aborts
//   rx_valid   single-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   wr_en      image RAM write strobe, one cycle per accepted byte
//   wr_addr    image RAM write address
//   wr_data    image RAM write data
//   cpu_hold   hold the CPU in reset / stall
//   busy       load in progress
//   done       last load completed successfully
//   err_code   0 none, 1 bad magic, 2 unsupported format, 3 aborted,
//              4 timeout
//   checksum   mod-256 sum of every byte accepted in the current load
//   state_dbg  current FSM state, for observation only
//
// Handshake: the receiver offers a byte by raising rx_valid for exactly
// one cycle. There is no ready; a byte offered while the loader is in an
// active state (HDR/PRG/CHR) and prg_ctrl is high is always taken. Bytes
// offered in any other state, or in the cycle of an abort, are dropped.
// Each taken byte produces wr_en on the next cycle, so back-to-back bytes
// give back-to-back writes.
// ---------------------------------------------------------------------------
module rom_loader #(
    parameter int          HDR_BYTES   = 16,
    parameter int          PRG_BYTES   = 16384,
    parameter int          CHR_BYTES   = 8192,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        prg_ctrl,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err_code,
    output logic [7:0]  checksum,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PRG  = 3'd2,
        S_CHR  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_MAGIC   = 3'd1;
    localparam logic [2:0] ERR_FORMAT  = 3'd2;
    localparam logic [2:0] ERR_ABORT   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Byte-count values at which each section is complete.
    localparam logic [14:0] HDR_END = 15'(HDR_BYTES);
    localparam logic [14:0] PRG_END = 15'(HDR_BYTES + PRG_BYTES);
    localparam logic [14:0] CHR_END = 15'(HDR_BYTES + PRG_BYTES + CHR_BYTES);

    state_t      r_state;
    logic        r_prg_q;
    logic [14:0] r_cnt;
    logic [23:0] r_tmo;

    logic        w_active;
    logic        w_start;
    logic        w_abort;
    logic        w_timeout;
    logic [14:0] w_cnt_next;
    logic [2:0]  w_hdr_code;

    assign w_active   = (r_state == S_HDR) || (r_state == S_PRG) ||
                        (r_state == S_CHR);
    assign w_start    = prg_ctrl & ~r_prg_q;
    assign w_abort    = w_active & ~prg_ctrl;
    // The counter is about to reach TIMEOUT_CYC on this idle clock.
    assign w_timeout  = w_active & ~rx_valid &
                        (r_tmo == (TIMEOUT_CYC - 24'd1));
    assign w_cnt_next = r_cnt + 15'd1;

    // Header check for the byte at the current index. Only meaningful in
    // S_HDR, where r_cnt is always below 16.
    always_comb begin
        w_hdr_code = ERR_NONE;
        if (r_state == S_HDR) begin
            case (r_cnt[3:0])
                4'd0: if (rx_data != 8'h4E) w_hdr_code = ERR_MAGIC;
                4'd1: if (rx_data != 8'h45) w_hdr_code = ERR_MAGIC;
                4'd2: if (rx_data != 8'h53) w_hdr_code = ERR_MAGIC;
                4'd3: if (rx_data != 8'h1A) w_hdr_code = ERR_MAGIC;
                4'd4: if (rx_data != 8'h01) w_hdr_code = ERR_FORMAT;
                4'd5: if (rx_data != 8'h01) w_hdr_code = ERR_FORMAT;
                4'd6: if (rx_data[7:4] != 4'h0) w_hdr_code = ERR_FORMAT;
                4'd7: if (rx_data[7:4] != 4'h0) w_hdr_code = ERR_FORMAT;
                default: w_hdr_code = ERR_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            // Reset to 1 so a request level held high across reset is not
            // mistaken for a fresh start edge.
            r_prg_q  <= 1'b1;
            r_cnt    <= 15'd0;
            r_tmo    <= 24'd0;
            wr_en    <= 1'b0;
            wr_addr  <= 16'd0;
            wr_data  <= 8'd0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_NONE;
            checksum <= 8'd0;
        end else begin
            r_prg_q <= prg_ctrl;
            wr_en   <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_start) begin
                        r_state  <= S_HDR;
                        r_cnt    <= 15'd0;
                        r_tmo    <= 24'd0;
                        checksum <= 8'd0;
                        err_code <= ERR_NONE;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end

                S_HDR, S_PRG, S_CHR: begin
                    if (w_abort) begin
                        // Coincident byte is dropped; cpu_hold stays high.
                        r_state  <= S_ERR;
                        err_code <= ERR_ABORT;
                        busy     <= 1'b0;
                    end else if (w_timeout) begin
                        r_state  <= S_ERR;
                        err_code <= ERR_TIMEOUT;
                        busy     <= 1'b0;
                    end else if (rx_valid) begin
                        // Accept the byte; a failing header byte is still
                        // written and summed before the load stops.
                        wr_en    <= 1'b1;
                        wr_addr  <= {1'b0, r_cnt};
                        wr_data  <= rx_data;
                        r_cnt    <= w_cnt_next;
                        checksum <= checksum + rx_data;
                        r_tmo    <= 24'd0;

                        if (w_hdr_code != ERR_NONE) begin
                            r_state  <= S_ERR;
                            err_code <= w_hdr_code;
                            busy     <= 1'b0;
                        end else if ((r_state == S_HDR) &&
                                     (w_cnt_next == HDR_END)) begin
                            r_state <= S_PRG;
                        end else if ((r_state == S_PRG) &&
                                     (w_cnt_next == PRG_END)) begin
                            r_state <= S_CHR;
                        end else if ((r_state == S_CHR) &&
                                     (w_cnt_next == CHR_END)) begin
                            r_state  <= S_DONE;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            err_code <= ERR_NONE;
                        end
                    end else begin
                        r_tmo <= r_tmo + 24'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = r_state;

endmodule
